// File: rtl/err_ser_pkg.sv
// Shared types and constants for the error-counter frame serializer and its host-side decoder.
package err_ser_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      PAR  = 2'd3
   } ser_state_e;

   // Default frame header; the host decoder searches for this pattern.
   localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;

   // Bits per frame: header + payload + parity.
   function automatic int unsigned frame_len(input int unsigned sync_w,
                                             input int unsigned n_ch,
                                             input int unsigned cnt_w);
      return sync_w + n_ch * cnt_w + 1;
   endfunction

endpackage

// File: rtl/err_snapshot_bank.sv
// Snapshot register bank holding all counters, with a per-channel/bit serial read mux.
module err_snapshot_bank #(
   parameter int unsigned N_CH      = 10,
   parameter int unsigned CNT_W     = 12,
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
   parameter int unsigned BIC_W     = (CNT_W > 1) ? $clog2(CNT_W) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [N_CH*CNT_W-1:0]   din,
   input  logic [CH_W-1:0]         ch,
   input  logic [BIC_W-1:0]        bic,
   output logic                    bit_c
);

   localparam int unsigned PAY_W = N_CH * CNT_W;
   localparam int unsigned IDX_W = (PAY_W > 1) ? $clog2(PAY_W) : 1;

   logic [PAY_W-1:0] snap_q;
   logic [PAY_W-1:0] snap_d;
   logic [BIC_W-1:0] bit_sel;
   logic [IDX_W-1:0] idx;

   // Capture all counters at once when loading, otherwise hold.
   always_comb begin
      snap_d = snap_q;
      if (load) begin
         snap_d = din;
      end
   end

   // Snapshot storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q <= '0;
      end else begin
         snap_q <= snap_d;
      end
   end

   // Select the payload bit for (channel, bit-within-channel) in the configured order.
   always_comb begin
      bit_sel = MSB_FIRST ? (BIC_W'(CNT_W - 1) - bic) : bic;
      idx     = IDX_W'(ch) * IDX_W'(CNT_W) + IDX_W'(bit_sel);
      bit_c   = snap_q[idx];
   end

endmodule

// File: rtl/err_cnt_frame_serializer.sv
// Serializes a snapshot of N_CH error counters as header + payload + even-parity frames.
module err_cnt_frame_serializer
   import err_ser_pkg::*;
#(
   parameter int unsigned       N_CH       = 10,
   parameter int unsigned       CNT_W      = 12,
   parameter int unsigned       SYNC_W     = 8,
   parameter logic [SYNC_W-1:0] SYNC_WORD  = SYNC_W'(DEF_SYNC_WORD),
   parameter bit                MSB_FIRST  = 1'b0,
   parameter bit                CONTINUOUS = 1'b1
) (
   input  logic                  data_clk,
   input  logic                  reset,
   input  logic                  save_data,
   input  logic [N_CH*CNT_W-1:0] err_cnt,
   output logic                  DATA_OUT,
   output logic                  frame_sync,
   output logic                  busy,
   output logic                  capture_dropped
);

   localparam int unsigned PAY_W  = N_CH * CNT_W;
   localparam int unsigned BIT_W  = (PAY_W > 1) ? $clog2(PAY_W) : 1;
   localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned BIC_W  = (CNT_W > 1) ? $clog2(CNT_W) : 1;
   localparam int unsigned HDR_IW = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;

   ser_state_e        state_q, state_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [BIC_W-1:0]  bic_q, bic_d;
   logic              par_q, par_d;
   logic              pend_q, pend_d;
   logic              save_q, save_d;
   logic              data_out_q, data_out_d;
   logic              frame_sync_q, frame_sync_d;
   logic              busy_q, busy_d;
   logic              drop_q, drop_d;

   logic              req;
   logic              load;
   logic              bank_bit;
   logic [HDR_IW-1:0] hdr_idx;

   err_snapshot_bank #(
      .N_CH      (N_CH),
      .CNT_W     (CNT_W),
      .MSB_FIRST (MSB_FIRST),
      .CH_W      (CH_W),
      .BIC_W     (BIC_W)
   ) u_bank (
      .clk   (data_clk),
      .rst   (reset),
      .load  (load),
      .din   (err_cnt),
      .ch    (ch_q),
      .bic   (bic_q),
      .bit_c (bank_bit)
   );

   // Next-state, counters, parity, pending/drop and the registered serial outputs.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      ch_d         = ch_q;
      bic_d        = bic_q;
      par_d        = par_q;
      pend_d       = pend_q;
      save_d       = save_data;
      data_out_d   = 1'b0;
      frame_sync_d = 1'b0;
      drop_d       = 1'b0;
      load         = 1'b0;
      req          = save_data & ~save_q;
      hdr_idx      = HDR_IW'(SYNC_W - 1) - HDR_IW'(bit_cnt_q);

      unique case (state_q)
         IDLE: begin
            if (req) begin
               load    = 1'b1;
               state_d = HDR;
               par_d   = 1'b0;
            end
         end
         HDR: begin
            data_out_d   = SYNC_WORD[hdr_idx];
            frame_sync_d = (bit_cnt_q == '0);
            if (bit_cnt_q == BIT_W'(SYNC_W - 1)) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end
         DATA: begin
            data_out_d = bank_bit;
            par_d      = par_q ^ bank_bit;
            if (bit_cnt_q == BIT_W'(PAY_W - 1)) begin
               state_d   = PAR;
               bit_cnt_d = '0;
               ch_d      = '0;
               bic_d     = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bic_q == BIC_W'(CNT_W - 1)) begin
                  bic_d = '0;
                  ch_d  = ch_q + CH_W'(1);
               end else begin
                  bic_d = bic_q + BIC_W'(1);
               end
            end
         end
         PAR: begin
            data_out_d = par_q;
            // A fresh request on the last frame cycle is taken directly, like a consumed pending one.
            if (pend_q || req) begin
               load    = 1'b1;
               state_d = HDR;
               par_d   = 1'b0;
            end else if (CONTINUOUS) begin
               state_d = HDR;
               par_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_q == PAR) begin
         pend_d = pend_q & req;
      end else if (state_q != IDLE && req) begin
         if (pend_q) begin
            drop_d = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge data_clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         ch_q         <= '0;
         bic_q        <= '0;
         par_q        <= 1'b0;
         pend_q       <= 1'b0;
         save_q       <= 1'b0;
         data_out_q   <= 1'b0;
         frame_sync_q <= 1'b0;
         busy_q       <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         ch_q         <= ch_d;
         bic_q        <= bic_d;
         par_q        <= par_d;
         pend_q       <= pend_d;
         save_q       <= save_d;
         data_out_q   <= data_out_d;
         frame_sync_q <= frame_sync_d;
         busy_q       <= busy_d;
         drop_q       <= drop_d;
      end
   end

   assign DATA_OUT        = data_out_q;
   assign frame_sync      = frame_sync_q;
   assign busy            = busy_q;
   assign capture_dropped = drop_q;

endmodule
